// File: rtl/fir_mac_sequencer.sv
// Time-multiplexed FIR controller: one shared multiplier swept over TAPS coefficients per sample.
// Optional output saturation via macro FIR_SEQ_SAT_EN (undefined: truncate to OW bits, out_ovf tied 0).
module fir_mac_sequencer #(
    parameter int TAPS  = 4,
    parameter int DW    = 8,
    parameter int CW    = 8,
    parameter int OW    = 10,
    parameter int SHIFT = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    input  logic [DW-1:0]           in_data,
    output logic                    in_ready,
    output logic                    out_valid,
    output logic [OW-1:0]           out_data,
    input  logic                    out_ready,
    output logic                    out_ovf,
    input  logic                    cfg_we,
    input  logic [$clog2(TAPS)-1:0] cfg_addr,
    input  logic [CW-1:0]           cfg_data,
    output logic                    cfg_err,
    output logic                    busy
);

    localparam int AW   = $clog2(TAPS);
    localparam int MW   = (DW > CW) ? DW : CW;
    localparam int ACCW = 2 * MW + AW;
    localparam int PW   = DW + CW;

    localparam logic [AW-1:0] LAST    = AW'(TAPS - 1);
    localparam logic [AW-1:0] TAPS_AW = AW'(TAPS);
    localparam logic [AW:0]   TAPS_W  = (AW + 1)'(TAPS);

    typedef enum logic [1:0] {
        S_IDLE,
        S_MAC,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [DW-1:0]     delay_q [TAPS];
    logic [DW-1:0]     delay_d [TAPS];
    logic [CW-1:0]     coef_q  [TAPS];
    logic [CW-1:0]     coef_d  [TAPS];
    logic [AW-1:0]     wptr_q, wptr_d;
    logic [AW-1:0]     newest_q, newest_d;
    logic [AW-1:0]     k_q, k_d;
    logic [ACCW-1:0]   acc_q, acc_d;
    logic              out_valid_q, out_valid_d;
    logic [OW-1:0]     out_data_q, out_data_d;
    logic              cfg_err_q, cfg_err_d;

    logic              cfg_addr_ok;
    logic [AW-1:0]     mac_idx;
    logic [PW-1:0]     prod;
    logic [ACCW-1:0]   acc_sum;
    logic [ACCW-1:0]   shifted;
    logic [OW-1:0]     data_fmt;

    assign cfg_addr_ok = ({1'b0, cfg_addr} < TAPS_W);

    // Tap k reads the sample written k accepts ago; adding TAPS (mod 2^AW) keeps the
    // wrap correct for non-power-of-two TAPS and collapses to plain wrap otherwise.
    assign mac_idx = newest_q - k_q + ((newest_q >= k_q) ? '0 : TAPS_AW);
    assign prod    = coef_q[k_q] * delay_q[mac_idx];
    assign acc_sum = acc_q + ACCW'(prod);
    assign shifted = acc_sum >> SHIFT;

`ifdef FIR_SEQ_SAT_EN
    logic ovf_fmt;
    logic out_ovf_q, out_ovf_d;

    assign ovf_fmt  = ((shifted >> OW) != '0);
    assign data_fmt = ovf_fmt ? '1 : OW'(shifted);
    assign out_ovf  = out_ovf_q;
`else
    assign data_fmt = OW'(shifted);
    assign out_ovf  = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        delay_d     = delay_q;
        coef_d      = coef_q;
        wptr_d      = wptr_q;
        newest_d    = newest_q;
        k_d         = k_q;
        acc_d       = acc_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        cfg_err_d   = 1'b0;
`ifdef FIR_SEQ_SAT_EN
        out_ovf_d   = out_ovf_q;
`endif
        in_ready    = 1'b0;
        busy        = 1'b0;

        // The MAC walks coef_q, so writes are only safe outside MAC.
        if (cfg_we) begin
            if (state_q == S_MAC || !cfg_addr_ok) begin
                cfg_err_d = 1'b1;
            end else begin
                coef_d[cfg_addr] = cfg_data;
            end
        end

        case (state_q)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    delay_d[wptr_q] = in_data;
                    newest_d        = wptr_q;
                    wptr_d          = (wptr_q == LAST) ? '0 : wptr_q + 1'b1;
                    acc_d           = '0;
                    k_d             = '0;
                    state_d         = S_MAC;
                end
            end
            S_MAC: begin
                busy  = 1'b1;
                acc_d = acc_sum;
                k_d   = k_q + 1'b1;
                if (k_q == LAST) begin
                    k_d         = '0;
                    out_data_d  = data_fmt;
`ifdef FIR_SEQ_SAT_EN
                    out_ovf_d   = ovf_fmt;
`endif
                    out_valid_d = 1'b1;
                    state_d     = S_DONE;
                end
            end
            S_DONE: begin
                busy = 1'b1;
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            delay_q     <= '{default: '0};
            coef_q      <= '{default: CW'(1)};
            wptr_q      <= '0;
            newest_q    <= '0;
            k_q         <= '0;
            acc_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            cfg_err_q   <= 1'b0;
`ifdef FIR_SEQ_SAT_EN
            out_ovf_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            delay_q     <= delay_d;
            coef_q      <= coef_d;
            wptr_q      <= wptr_d;
            newest_q    <= newest_d;
            k_q         <= k_d;
            acc_q       <= acc_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            cfg_err_q   <= cfg_err_d;
`ifdef FIR_SEQ_SAT_EN
            out_ovf_q   <= out_ovf_d;
`endif
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign cfg_err   = cfg_err_q;

endmodule
